// File: rtl/ip_bus_initiator.sv
// ip_bus_initiator: single-transaction peripheral bus master with valid/ready command input and read response pulse
// Ports: clk, reset (async, active high); cmd_valid/cmd_ready/cmd_write/cmd_memory/cmd_address/cmd_wdata command in;
//        rsp_valid/rsp_rdata/rsp_timeout read response out; busy; bus_address/bus_write_data/bus_memory/bus_read/bus_write
//        bus request out; bus_read_ready/bus_read_data responder return in.
// Optional macro IP_BUS_INITIATOR_TIMEOUT_EN builds the read timeout (TIMEOUT_CYCLES); otherwise reads wait forever.
module ip_bus_initiator #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_memory,
  input  logic [15:0] cmd_address,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_memory,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_RD = 2'd2, S_GAP = 2'd3;
  logic [1:0] r_state;
  logic       r_write;
  logic [3:0] r_gap;
  logic       w_to_hit;
  logic [1:0] w_done_st;
  logic       w_rd_done;
  assign w_done_st = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
  assign w_rd_done = (r_state == S_WAIT_RD) && (bus_read_ready || w_to_hit);
  assign cmd_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  // strobes decode from the async-reset state so they drop immediately on reset
  assign bus_write = (r_state == S_ISSUE) && r_write;
  assign bus_read  = (r_state == S_ISSUE) && !r_write;
`ifdef IP_BUS_INITIATOR_TIMEOUT_EN
  logic [7:0] r_to_cnt;
  logic       r_rsp_to;
  // counter holds the number of WAIT_RD cycles already elapsed, so the limit fires at the end of the last allowed cycle
  assign w_to_hit    = r_to_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign rsp_timeout = r_rsp_to;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= 8'h00;
      r_rsp_to <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_WAIT_RD) ? r_to_cnt + 8'h01 : 8'h00;
      r_rsp_to <= w_rd_done && !bus_read_ready;
    end
  end
`else
  assign w_to_hit    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_write        <= 1'b0;
      r_gap          <= 4'h0;
      bus_address    <= 16'h0000;
      bus_write_data <= 8'h00;
      bus_memory     <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 8'h00;
    end else begin
      rsp_valid <= w_rd_done;
      if (w_rd_done) rsp_rdata <= bus_read_ready ? bus_read_data : 8'hFF;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_state        <= S_ISSUE;
          r_write        <= cmd_write;
          bus_address    <= cmd_address;
          bus_write_data <= cmd_wdata;
          bus_memory     <= cmd_memory;
        end
        S_ISSUE: begin
          r_gap   <= 4'h0;
          r_state <= r_write ? w_done_st : S_WAIT_RD;
        end
        S_WAIT_RD: if (w_rd_done) begin
          r_gap   <= 4'h0;
          r_state <= w_done_st;
        end
        default: begin
          r_gap   <= r_gap + 4'h1;
          r_state <= (r_gap == 4'(GAP_CYCLES - 1)) ? S_IDLE : S_GAP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ip_bus_initiator.sv
// tb_ip_bus_initiator: directed vector bench for ip_bus_initiator (GAP_CYCLES=2 instance plus GAP_CYCLES=0 back-to-back instance)
module tb_ip_bus_initiator;
  localparam int GAP = 2;
  localparam int TO  = 4;
`ifdef IP_BUS_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 0, cmd_write = 0, cmd_memory = 0, bus_read_ready = 0;
  logic [15:0] cmd_address = 0;
  logic [7:0] cmd_wdata = 0, bus_read_data = 0;
  logic cmd_ready, rsp_valid, rsp_timeout, busy, bus_memory, bus_read, bus_write;
  logic [7:0] rsp_rdata, bus_write_data;
  logic [15:0] bus_address;
  logic b_valid = 0;
  logic [15:0] b_addr = 0;
  logic [7:0] b_wdata = 0;
  logic b_ready, b_rsp_valid, b_rsp_timeout, b_busy, b_memory, b_read, b_write;
  logic [7:0] b_rsp_rdata, b_bus_wdata;
  logic [15:0] b_bus_addr;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  ip_bus_initiator #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_memory(cmd_memory), .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_memory(bus_memory), .bus_read(bus_read), .bus_write(bus_write),
    .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data));
  ip_bus_initiator #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) u_b2b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(1'b1),
    .cmd_memory(1'b1), .cmd_address(b_addr), .cmd_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_timeout(b_rsp_timeout), .busy(b_busy), .bus_address(b_bus_addr),
    .bus_write_data(b_bus_wdata), .bus_memory(b_memory), .bus_read(b_read), .bus_write(b_write),
    .bus_read_ready(1'b0), .bus_read_data(8'h00));
  typedef struct {
    logic        wr;
    logic        mem;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          dly;
    logic [7:0]  rdata;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string name);
    chk({name, " no rsp"}, rsp_valid, 0);
    chk({name, " no strobe"}, {bus_read, bus_write}, 0);
  endtask
  task automatic run_vec(input vec_t v);
    bit to_exp;
    int n, g;
    to_exp = TO_EN && !v.wr && v.dly >= TO;
    chk("ready before cmd", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.wr; cmd_memory = v.mem; cmd_address = v.addr; cmd_wdata = v.wdata;
    step();
    cmd_valid = 0; cmd_address = ~v.addr; cmd_wdata = ~v.wdata; cmd_memory = ~v.mem;
    chk("strobe wr", bus_write, v.wr);
    chk("strobe rd", bus_read, !v.wr);
    chk("addr", bus_address, v.addr);
    chk("wdata", bus_write_data, v.wdata);
    chk("mem", bus_memory, v.mem);
    chk("ready low in issue", cmd_ready, 0);
    chk("busy in issue", busy, 1);
    if (!v.wr) begin
      n = to_exp ? TO - 1 : v.dly;
      repeat (n) begin step(); idle_chk("wait"); end
      step();
      idle_chk("wait last");
      if (!to_exp) begin bus_read_ready = 1; bus_read_data = v.rdata; end
      step();
      bus_read_ready = 0; bus_read_data = 8'h5E;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, to_exp ? 8'hFF : v.rdata);
      chk("rsp_timeout", rsp_timeout, to_exp);
      chk("ready low in rsp", cmd_ready, 0);
    end
    g = v.wr ? GAP : GAP - 1;
    repeat (g) begin step(); idle_chk("gap"); chk("ready low in gap", cmd_ready, 0); end
    step();
    idle_chk("back idle");
    chk("ready back", cmd_ready, 1);
    chk("addr held", bus_address, v.addr);
  endtask
  initial begin
    int idx, sc, last;
    bit acc;
    vecs[0] = '{1'b1, 1'b1, 16'h9800, 8'h5A, 0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 16'h9880, 8'h00, 2, 8'hC3};
    vecs[2] = '{1'b0, 1'b1, 16'h1234, 8'h00, 0, 8'h3C};
    vecs[3] = '{1'b1, 1'b0, 16'h00FF, 8'hA5, 0, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 16'hABCD, 8'h00, 3, 8'h5A};
    vecs[5] = '{1'b0, 1'b1, 16'h4321, 8'h00, 6, 8'h77};
    vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 8'h00, 0, 8'h00};
    #1;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    chk("rst bus", {bus_address, bus_write_data, bus_memory, bus_read, bus_write}, 0);
    step(); step();
    reset = 0;
    step();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    // spurious ready across IDLE, ISSUE and GAP of a write
    bus_read_ready = 1; bus_read_data = 8'h11;
    cmd_valid = 1; cmd_write = 1; cmd_address = 16'h2222;
    step();
    cmd_valid = 0;
    repeat (5) begin step(); idle_chk("spurious wr"); end
    // ready during ISSUE of a read is ignored; later ready in WAIT_RD delivers its own data
    bus_read_ready = 0;
    cmd_valid = 1; cmd_write = 0; cmd_address = 16'h3333;
    step();
    cmd_valid = 0; bus_read_ready = 1; bus_read_data = 8'h11;
    step();
    bus_read_ready = 0;
    idle_chk("spurious issue");
    step();
    bus_read_ready = 1; bus_read_data = 8'h22;
    idle_chk("wait after spurious");
    step();
    bus_read_ready = 0;
    chk("rsp after spurious", {rsp_valid, rsp_rdata}, {1'b1, 8'h22});
    repeat (3) step();
    // reset mid WAIT_RD
    chk("ready pre-rst", cmd_ready, 1);
    cmd_valid = 1; cmd_address = 16'h5555; cmd_write = 0;
    step();
    cmd_valid = 0;
    step();
    chk("busy in wait", busy, 1);
    #3 reset = 1;
    #1;
    chk("async rst ready", cmd_ready, 1);
    chk("async rst busy", busy, 0);
    chk("async rst bus", {bus_address, bus_read, bus_write}, 0);
    chk("async rst rsp", {rsp_valid, rsp_rdata}, 0);
    bus_read_ready = 1; bus_read_data = 8'h99;
    step();
    reset = 0;
    repeat (3) begin step(); chk("no rsp after rst", {rsp_valid, busy}, 0); end
    bus_read_ready = 0;
    // back-to-back writes on the GAP_CYCLES=0 instance
    idx = 0; sc = 0; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      b_valid = idx < 8; b_addr = 16'h1000 + 16'(idx); b_wdata = 8'(idx);
      acc = b_ready && b_valid;
      step();
      if (acc) idx++;
      if (b_read) chk("b2b no read", b_read, 0);
      if (b_write) begin
        chk("b2b addr", b_bus_addr, 16'h1000 + 16'(sc));
        chk("b2b data", b_bus_wdata, 8'(sc));
        if (sc > 0) chk("b2b spacing", cyc - last, 2);
        last = cyc; sc++;
      end
    end
    chk("b2b strobes", sc, 8);
    chk("b2b accepted", idx, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
